dpsk_word_sched: RTL and testbench
==================================

Name: dpsk_word_sched

Overview:
- Sequences the 12-bit serial DPSK differential encoder and shares it between two word sources.
- Round-robin arbitrates two valid/ready requesters and issues the granted word with a one-cycle start pulse.
- Tracks the encoder's 12 bit-periods so that back-to-back words run gaplessly.
- Tags each output bit with its source, counts words into frames, and flags any mismatch with the encoder's result_out.

Parameters:
- WORD_W, 12, word width; must equal the encoder word width.
- FRAME_WORDS, 8, words per frame; range 1..255.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WORD_W.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enables new grants; does not stop a word already in flight.
- req_valid  in  2  per-source word valid.
- req_word0  in  WORD_W  source 0 word.
- req_word1  in  WORD_W  source 1 word.
- req_ready  out  2  one-hot grant; a transfer occurs when valid and ready are both high.
- enc_start  out  1  drives the encoder's receive_word.
- enc_word  out  WORD_W  drives the encoder's word; meaningful only while enc_start=1.
- enc_result_out  in  1  encoder's result_out, used for checking.
- bit_valid  out  1  an encoder output bit is valid this cycle.
- bit_src  out  1  source of the current bit.
- bit_last  out  1  the current bit is bit 0 of its word.
- busy  out  1  a word is in flight after its start cycle.
- frame_done  out  1  one-cycle pulse on the last bit of the FRAME_WORDS-th word.
- err  out  1  sticky; set when enc_result_out != bit_valid.

Behaviour:
- Reset values:
  - state=IDLE, bit_cnt=0, rr_ptr=0 (source 0 has priority first), word_cnt=0, cur_src=0, err=0.
  - All outputs are 0.
  - The encoder shares rst, so both blocks return to idle together.
- States: IDLE, BUSY.
- IDLE:
  - When en=1 and any req_valid=1, issue a word in the same cycle (combinational grant).
  - Grant rule: if both sources are valid, grant rr_ptr; otherwise grant the single valid source.
  - In the issue cycle: req_ready[g]=1, enc_start=1, enc_word=req_word{g}, bit_valid=1, bit_src=g.
  - Registered updates on issue: cur_src<=g, rr_ptr<=~g, bit_cnt<=WORD_W-2, state<=BUSY.
  - When en=0 or no request is valid, outputs stay 0 and the state holds.
- BUSY:
  - Outputs: bit_valid=1, busy=1, bit_src=cur_src, enc_start=0, req_ready=0.
  - bit_cnt decrements each cycle. At bit_cnt==0: bit_last=1 and next state is IDLE.
- Timing:
  - A start in cycle T produces bits in cycles T..T+WORD_W-1.
  - The earliest next start is T+WORD_W, giving gapless back-to-back words.
  - enc_start is never asserted while busy=1; asserting it would corrupt the encoder.
- Frame counting:
  - On bit_last, word_cnt increments.
  - If word_cnt==FRAME_WORDS-1: frame_done=1 that cycle and word_cnt<=0.
  - For FRAME_WORDS=1, frame_done accompanies every bit_last.
- en deasserted mid-word: the current word completes normally; no new grant is made until en=1.
- A requester that drops valid before it is granted loses nothing. rr_ptr changes only on a grant.
- err:
  - Compared every cycle: set if enc_result_out differs from bit_valid.
  - Sticky until rst.
- Reset mid-word:
  - Abandons the word; no bit_last and no frame_done.
  - A partial frame count is discarded.

Decomposition:
- Shared dpsk package holds:
  - word-width constant 12;
  - FRAME_WORDS default;
  - state encoding (IDLE=0, BUSY=1).
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter (valid, ptr -> one-hot grant).
- Registers use the team's existing dffr flop.

Test Plan:
- Single word: reset, req_valid=01, word0=0xA5C, en=1.
  - Required: ready0=1 and enc_start in cycle T.
  - Required: bit_valid high for 12 cycles, bit_last at T+11, busy low at T+12, err=0.
- Contention: both sources valid continuously, words 0x111 and 0x222.
  - Required: grants alternate 0,1,0,1 at T, T+12, T+24, T+36.
  - Required: bit_src follows each grant; no idle gaps.
- Frame pulse: FRAME_WORDS=3, source 0 valid continuously.
  - Required: frame_done pulses exactly at T+35 and T+71.
- Enable drop: en falls at T+5 of word 1 with a second word pending.
  - Required: word 1 completes to T+11; no grant while en=0; grant in the first cycle en=1 returns.
- Reset mid-word: rst at T+6.
  - Required: next cycle all outputs 0 and rr_ptr=0.
  - Required: a subsequent frame of 3 words gives frame_done on its third word.
- Checker: force enc_result_out=0 during a busy cycle.
  - Required: err=1 from the next cycle and held until rst.

Source files
------------

// File: rtl/dpsk_word_sched_pkg.sv
// Shared definitions for the DPSK word scheduler: word width, frame
// length default and FSM state encoding.
package dpsk_word_sched_pkg;

  localparam int DPSK_WORD_W      = 12;
  localparam int DPSK_FRAME_WORDS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

endpackage

// File: rtl/dpsk_word_sched_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from a pair of valids and a
// priority pointer (ptr_i selects the winner only under contention).
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid_i == 2'b11) begin
      grant_o = ptr_i ? 2'b10 : 2'b01;
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/dpsk_word_sched.sv
// Shares one 12-bit serial DPSK encoder between two word sources: grants,
// sequences the bit periods, tags bits, counts frames and checks result_out.
module dpsk_word_sched
  import dpsk_word_sched_pkg::*;
#(
  parameter int WORD_W      = DPSK_WORD_W,
  parameter int FRAME_WORDS = DPSK_FRAME_WORDS,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        req_valid,
  input  logic [WORD_W-1:0] req_word0,
  input  logic [WORD_W-1:0] req_word1,
  output logic [1:0]        req_ready,
  output logic              enc_start,
  output logic [WORD_W-1:0] enc_word,
  input  logic              enc_result_out,
  output logic              bit_valid,
  output logic              bit_src,
  output logic              bit_last,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic             cur_src_q, cur_src_d;
  logic             err_q, err_d;

  logic [1:0] arb_valid;
  logic [1:0] grant;
  logic       issue;
  logic       grant_src;
  logic       in_busy;

  // Requests are only visible to the arbiter while idle, enabled and out of reset.
  assign arb_valid = (state_q == IDLE && en && !rst) ? req_valid : 2'b00;

  rr_arb2 u_arb (
    .valid_i (arb_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  assign issue     = |grant;
  assign grant_src = grant[1];
  assign in_busy   = (state_q == BUSY);

  assign req_ready  = grant;
  assign enc_start  = issue;
  assign enc_word   = issue ? (grant_src ? req_word1 : req_word0) : '0;
  assign bit_valid  = issue | in_busy;
  assign bit_src    = issue ? grant_src : (in_busy & cur_src_q);
  assign busy       = in_busy;
  assign bit_last   = in_busy && (bit_cnt_q == '0);
  assign frame_done = bit_last && (word_cnt_q == 8'(FRAME_WORDS - 1));
  assign err        = err_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    cur_src_d  = cur_src_q;
    err_d      = err_q | (enc_result_out != bit_valid);

    if (issue) begin
      cur_src_d = grant_src;
      rr_ptr_d  = ~grant_src;
      bit_cnt_d = CNT_W'(WORD_W - 2);
      state_d   = BUSY;
    end else if (in_busy) begin
      if (bit_cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
      end
    end

    if (bit_last) begin
      word_cnt_d = frame_done ? 8'd0 : word_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rr_ptr_q   <= 1'b0;
      word_cnt_q <= 8'd0;
      cur_src_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      word_cnt_q <= word_cnt_d;
      cur_src_q  <= cur_src_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_dpsk_word_sched.sv
// Directed bench for dpsk_word_sched: a grant vector table plus hand-written
// multi-cycle sequences, with a simple stand-in for the serial encoder.
module tb_dpsk_word_sched;

  localparam int WORD_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [1:0]        reqValid;
  logic [WORD_W-1:0] reqWord0, reqWord1;
  logic              encResult;
  logic              forceZero;

  logic [1:0]        reqReady, reqReady1;
  logic              encStart, encStart1;
  logic [WORD_W-1:0] encWord, encWord1;
  logic              bitValid, bitValid1, bitSrc, bitSrc1, bitLast, bitLast1;
  logic              busy, busy1, frameDone, frameDone1, err, err1;

  logic [20:0] outVec0, outVec1;
  logic [3:0]  mCnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dpsk_word_sched #(.WORD_W(WORD_W), .FRAME_WORDS(3), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(reqValid),
    .req_word0(reqWord0), .req_word1(reqWord1), .req_ready(reqReady),
    .enc_start(encStart), .enc_word(encWord), .enc_result_out(encResult),
    .bit_valid(bitValid), .bit_src(bitSrc), .bit_last(bitLast),
    .busy(busy), .frame_done(frameDone), .err(err)
  );

  dpsk_word_sched #(.WORD_W(WORD_W), .FRAME_WORDS(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .req_valid(reqValid),
    .req_word0(reqWord0), .req_word1(reqWord1), .req_ready(reqReady1),
    .enc_start(encStart1), .enc_word(encWord1), .enc_result_out(encResult),
    .bit_valid(bitValid1), .bit_src(bitSrc1), .bit_last(bitLast1),
    .busy(busy1), .frame_done(frameDone1), .err(err1)
  );

  // Encoder stand-in: result_out high for the start cycle and 11 more.
  always_ff @(posedge clk) begin
    if (rst) mCnt <= 4'd0;
    else if (encStart) mCnt <= 4'd11;
    else if (mCnt != 4'd0) mCnt <= mCnt - 4'd1;
  end
  assign encResult = forceZero ? 1'b0 : (encStart || (mCnt != 4'd0));

  assign outVec0 = {reqReady, encStart, encWord, bitValid, bitSrc, bitLast, busy, frameDone, err};
  assign outVec1 = {reqReady1, encStart1, encWord1, bitValid1, bitSrc1, bitLast1, busy1, frameDone1, err1};

  function automatic logic [20:0] mk(logic [1:0] rdy, logic st, logic [11:0] w, logic bv,
                                     logic src, logic last, logic bz, logic fd, logic er);
    return {rdy, st, w, bv, src, last, bz, fd, er};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] v, input logic [11:0] w0, input logic [11:0] w1);
    en       = e;
    reqValid = v;
    reqWord0 = w0;
    reqWord1 = w1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 12'h000, 12'h000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("waitIdle", {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    logic        en;
    logic [1:0]  valid;
    logic [11:0] w0;
    logic [11:0] w1;
    logic [1:0]  expReady;
    logic [11:0] expWord;
    logic        expSrc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    forceZero = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 12'h000, 12'h000);

    vecs[0] = '{1'b0, 2'b11, 12'h123, 12'h456, 2'b00, 12'h000, 1'b0};
    vecs[1] = '{1'b1, 2'b00, 12'h123, 12'h456, 2'b00, 12'h000, 1'b0};
    vecs[2] = '{1'b1, 2'b11, 12'h123, 12'h456, 2'b01, 12'h123, 1'b0};
    vecs[3] = '{1'b1, 2'b11, 12'h0F0, 12'hF0F, 2'b10, 12'hF0F, 1'b1};
    vecs[4] = '{1'b1, 2'b10, 12'hAAA, 12'h3C3, 2'b10, 12'h3C3, 1'b1};
    vecs[5] = '{1'b1, 2'b11, 12'h777, 12'h888, 2'b01, 12'h777, 1'b0};
    vecs[6] = '{1'b1, 2'b01, 12'hABC, 12'hDEF, 2'b01, 12'hABC, 1'b0};
    vecs[7] = '{1'b1, 2'b11, 12'hFFF, 12'h000, 2'b10, 12'h000, 1'b1};
    vecs[8] = '{1'b0, 2'b01, 12'h555, 12'h666, 2'b00, 12'h000, 1'b0};

    // Grant table: issue-cycle outputs under a running round-robin pointer.
    doReset();
    @(negedge clk);
    #1 checkOutput("resetState", {43'd0, outVec0}, 64'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].w0, vecs[i].w1);
      #1 checkOutput($sformatf("vec%0d", i), {43'd0, outVec0},
                     {43'd0, mk(vecs[i].expReady, |vecs[i].expReady, vecs[i].expWord,
                                |vecs[i].expReady, vecs[i].expSrc, 1'b0, 1'b0, 1'b0, 1'b0)});
      if (vecs[i].expReady != 2'b00) begin
        @(posedge clk);
        #1 applyStimulus(1'b1, 2'b00, 12'h000, 12'h000);
        waitIdle();
      end
    end

    // Single word timing.
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 12'hA5C, 12'h000);
    #1 checkOutput("single_k0", {43'd0, outVec0},
                   {43'd0, mk(2'b01, 1'b1, 12'hA5C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    @(posedge clk);
    #1 applyStimulus(1'b1, 2'b00, 12'h000, 12'h000);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k < 12)
        checkOutput($sformatf("single_k%0d", k), {43'd0, outVec0},
                    {43'd0, mk(2'b00, 1'b0, 12'h000, 1'b1, 1'b0, k == 11, 1'b1, 1'b0, 1'b0)});
      else
        checkOutput("single_k12", {43'd0, outVec0}, 64'd0);
    end

    // Contention: alternating grants, gapless.
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 12'h111, 12'h222);
    for (int c = 0; c < 48; c++) begin
      logic st, src;
      if (c > 0) @(negedge clk);
      #1;
      st  = (c % 12 == 0);
      src = ((c / 12) % 2) == 1;
      checkOutput($sformatf("contend_c%0d", c), {43'd0, outVec0},
                  {43'd0, mk(st ? (src ? 2'b10 : 2'b01) : 2'b00, st,
                             st ? (src ? 12'h222 : 12'h111) : 12'h000,
                             1'b1, src, (c % 12) == 11, !st, c == 35, 1'b0)});
    end
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 12'h000, 12'h000);
    waitIdle();

    // Frame pulses: FRAME_WORDS=3 on u_dut, FRAME_WORDS=1 on u_dut1.
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 12'h5A5, 12'h000);
    for (int c = 0; c < 72; c++) begin
      logic st, last;
      if (c > 0) @(negedge clk);
      #1;
      st   = (c % 12 == 0);
      last = (c % 12 == 11);
      checkOutput($sformatf("frame3_c%0d", c), {43'd0, outVec0},
                  {43'd0, mk(st ? 2'b01 : 2'b00, st, st ? 12'h5A5 : 12'h000,
                             1'b1, 1'b0, last, !st, (c == 35) || (c == 71), 1'b0)});
      checkOutput($sformatf("frame1_c%0d", c), {43'd0, outVec1},
                  {43'd0, mk(st ? 2'b01 : 2'b00, st, st ? 12'h5A5 : 12'h000,
                             1'b1, 1'b0, last, !st, last, 1'b0)});
    end
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 12'h000, 12'h000);
    waitIdle();

    // Enable drop mid-word with the other source pending.
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 12'hA0A, 12'hB0B);
    #1 checkOutput("endrop_c0", {43'd0, outVec0},
                   {43'd0, mk(2'b01, 1'b1, 12'hA0A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 5)  applyStimulus(1'b0, 2'b11, 12'hA0A, 12'hB0B);
      if (c == 15) applyStimulus(1'b1, 2'b11, 12'hA0A, 12'hB0B);
      #1;
      if (c <= 11)
        checkOutput($sformatf("endrop_c%0d", c), {43'd0, outVec0},
                    {43'd0, mk(2'b00, 1'b0, 12'h000, 1'b1, 1'b0, c == 11, 1'b1, 1'b0, 1'b0)});
      else if (c < 15)
        checkOutput($sformatf("endrop_c%0d", c), {43'd0, outVec0}, 64'd0);
      else
        checkOutput("endrop_c15", {43'd0, outVec0},
                    {43'd0, mk(2'b10, 1'b1, 12'hB0B, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)});
    end
    @(posedge clk);
    #1 applyStimulus(1'b1, 2'b00, 12'h000, 12'h000);
    waitIdle();

    // Reset mid-word, then a fresh three-word frame.
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 12'h123, 12'h000);
    #1 checkOutput("rstmid_c0", {43'd0, outVec0},
                   {43'd0, mk(2'b01, 1'b1, 12'h123, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) begin
        rst = 1'b1;
        applyStimulus(1'b1, 2'b00, 12'h000, 12'h000);
      end else begin
        #1 checkOutput($sformatf("rstmid_c%0d", c), {43'd0, outVec0},
                       {43'd0, mk(2'b00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("rstmid_zero", {43'd0, outVec0}, 64'd0);
    applyStimulus(1'b1, 2'b11, 12'h321, 12'h654);
    #1 checkOutput("rstmid_ptr0", {43'd0, outVec0},
                   {43'd0, mk(2'b01, 1'b1, 12'h321, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    for (int c = 1; c < 36; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rstframe_c%0d", c), {62'd0, bitLast, frameDone},
                  {62'd0, (c % 12) == 11, c == 35});
    end
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 12'h000, 12'h000);
    waitIdle();

    // Result checker: one busy cycle with result_out forced low.
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 12'hFED, 12'h000);
    @(posedge clk);
    #1 applyStimulus(1'b1, 2'b00, 12'h000, 12'h000);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      forceZero = (c == 3);
      #1 checkOutput($sformatf("err_c%0d", c), {62'd0, err, err1}, {62'd0, c >= 4, c >= 4});
    end
    doReset();
    @(negedge clk);
    checkOutput("err_cleared", {62'd0, err, err1}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

endmodule
